// File: rtl/eight_bit_divider.sv
// eight_bit_divider: sequential restoring divider, one trial subtraction per clock.
// Computes quotient and remainder of two WIDTH-bit operands behind a start/done
// handshake. Optional macro DIVIDER_SIGNED_EN selects two's-complement operands
// (truncating quotient, remainder signed like the dividend); undefined = unsigned.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        request, accepted only when idle
//   dividend     numerator, captured on the accepted start
//   divisor      denominator, captured on the accepted start
//   busy         high from the cycle after acceptance until done drops
//   done         single-cycle pulse, results valid from this cycle
//   quotient     result, held until the next done
//   remainder    result, held until the next done
//   div_by_zero  set with done when the divisor was zero, cleared on acceptance
module eight_bit_divider #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int unsigned CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] dvd_q;     // dividend shift register, MSB feeds the remainder
   logic [WIDTH-1:0] dvs_q;
   logic [WIDTH-1:0] rem_q;
   logic [WIDTH-1:0] quo_q;
   logic [CW-1:0]    count;
   logic             div0_q;

   logic [WIDTH:0]   shifted_c;
   logic [WIDTH:0]   diff_c;
   logic [WIDTH-1:0] dvd_mag_c;
   logic [WIDTH-1:0] dvs_mag_c;
   logic [WIDTH-1:0] r_mag_c;
   logic [WIDTH-1:0] q_fin_c;
   logic [WIDTH-1:0] r_fin_c;

   // Trial subtraction: partial remainder < divisor, so WIDTH+1 bits hold the
   // signed difference and its MSB is the borrow.
   always_comb begin
      shifted_c = {rem_q, dvd_q[WIDTH-1]};
      diff_c    = shifted_c - {1'b0, dvs_q};
   end

`ifdef DIVIDER_SIGNED_EN
   logic neg_q_q;
   logic neg_r_q;

   // Magnitudes at capture, signs re-applied when results are registered.
   // For divide-by-zero the dividend magnitude re-signed gives back the dividend.
   always_comb begin
      dvd_mag_c = dividend[WIDTH-1] ? (WIDTH'(0) - dividend) : dividend;
      dvs_mag_c = divisor[WIDTH-1]  ? (WIDTH'(0) - divisor)  : divisor;
      r_mag_c   = div0_q ? dvd_q : rem_q;
      q_fin_c   = div0_q ? '1 : (neg_q_q ? (WIDTH'(0) - quo_q) : quo_q);
      r_fin_c   = neg_r_q ? (WIDTH'(0) - r_mag_c) : r_mag_c;
   end

   // Result signs captured with the operands.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         neg_q_q <= 1'b0;
         neg_r_q <= 1'b0;
      end else if (state == IDLE && start) begin
         neg_q_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
         neg_r_q <= dividend[WIDTH-1];
      end
   end
`else
   // Unsigned: operands pass straight through, divide-by-zero forces the result.
   always_comb begin
      dvd_mag_c = dividend;
      dvs_mag_c = divisor;
      r_mag_c   = div0_q ? dvd_q : rem_q;
      q_fin_c   = div0_q ? '1 : quo_q;
      r_fin_c   = r_mag_c;
   end
`endif

   // Control FSM with datapath and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         dvd_q       <= '0;
         dvs_q       <= '0;
         rem_q       <= '0;
         quo_q       <= '0;
         count       <= '0;
         div0_q      <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         done <= 1'b0;
         // busy spans the done cycle; a same-edge acceptance below re-asserts it
         if (done) busy <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  dvd_q       <= dvd_mag_c;
                  dvs_q       <= dvs_mag_c;
                  rem_q       <= '0;
                  quo_q       <= '0;
                  count       <= '0;
                  div0_q      <= (divisor == '0);
                  div_by_zero <= 1'b0;
                  busy        <= 1'b1;
                  state       <= (divisor == '0) ? DONE : BUSY;
               end
            end
            BUSY: begin
               dvd_q <= dvd_q << 1;
               rem_q <= diff_c[WIDTH] ? shifted_c[WIDTH-1:0] : diff_c[WIDTH-1:0];
               quo_q <= {quo_q[WIDTH-2:0], ~diff_c[WIDTH]};
               count <= count + CW'(1);
               if (count == LAST_STEP) state <= DONE;
            end
            DONE: begin
               done        <= 1'b1;
               quotient    <= q_fin_c;
               remainder   <= r_fin_c;
               div_by_zero <= div0_q;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_eight_bit_divider.sv
// tb_eight_bit_divider: randomized and directed stimulus for eight_bit_divider.
// Stimulus pushes expected results (with acceptance and done cycles) into a
// scoreboard queue; a negedge monitor checks done timing, results, busy and
// result holding against it. Build with DIVIDER_SIGNED_EN to test signed mode.
module tb_eight_bit_divider;

   localparam int unsigned W = 8;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         f;
      int           acc;
      int           dcyc;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] dividend = '0;
   logic [W-1:0] divisor = '0;
   logic         busy;
   logic         done;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_by_zero;

   exp_t         scb[$];
   int           cyc = 0;
   int           n_cmp = 0;
   int           n_err = 0;
   logic [W-1:0] last_q = '0;
   logic [W-1:0] last_r = '0;
   logic         last_f = 1'b0;
   int           last_done = -1;

   eight_bit_divider #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
      end
   endtask

   // Reference: plain integer division with the divide-by-zero convention.
   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
`ifdef DIVIDER_SIGNED_EN
      int sa, sd, qi, ri;
`endif
      e.a = a; e.b = b; e.acc = 0; e.dcyc = 0;
      e.f = (b == 0);
      if (b == 0) begin
         e.q = '1;
         e.r = a;
      end else begin
`ifdef DIVIDER_SIGNED_EN
         sa = int'($signed(a));
         sd = int'($signed(b));
         qi = sa / sd;
         ri = sa % sd;
         e.q = qi[W-1:0];
         e.r = ri[W-1:0];
`else
         e.q = a / b;
         e.r = a % b;
`endif
      end
      return e;
   endfunction

   // Monitor: sampled on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (rst_n) begin
         logic exp_busy;
         logic exp_f;
         exp_busy = (last_done == cyc) || (scb.size() > 0 && cyc >= scb[0].acc);
         chk("busy", 32'(busy), 32'(exp_busy));
         if (done) begin
            if (scb.size() == 0) begin
               chk("unexpected_done", 32'(done), 32'd0);
            end else begin
               exp_t e;
               e = scb.pop_front();
               chk("done_cycle", 32'(cyc), 32'(e.dcyc));
               chk("quotient", 32'(quotient), 32'(e.q));
               chk("remainder", 32'(remainder), 32'(e.r));
               chk("div_by_zero", 32'(div_by_zero), 32'(e.f));
               last_q = e.q; last_r = e.r; last_f = e.f;
               last_done = cyc;
            end
         end else begin
            if (scb.size() > 0 && cyc > scb[0].dcyc) begin
               chk("missing_done", 32'(done), 32'd1);
               void'(scb.pop_front());
            end
            exp_f = (scb.size() > 0 && cyc >= scb[0].acc) ? 1'b0 : last_f;
            chk("hold_quotient", 32'(quotient), 32'(last_q));
            chk("hold_remainder", 32'(remainder), 32'(last_r));
            chk("hold_flag", 32'(div_by_zero), 32'(exp_f));
         end
      end
   end

   // Called at negedge+1; waits for the previous result, then pulses start.
   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
      int guard = 0;
      while (scb.size() != 0 && guard < 100) begin
         @(negedge clk); #1;
         guard++;
      end
      if (guard >= 100) begin
         chk("idle_timeout", 32'(scb.size()), 32'd0);
         scb.delete();
      end
      e = model(a, b);
      e.acc  = cyc + 1;
      e.dcyc = e.acc + ((b == 0) ? 1 : int'(W) + 1);
      scb.push_back(e);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      @(negedge clk); #1;
      start    = 1'b0;
      dividend = W'($urandom);
      divisor  = W'($urandom);
   endtask

   task automatic drain();
      int guard = 0;
      while (scb.size() != 0 && guard < 100) begin
         @(negedge clk); #1;
         guard++;
      end
      if (guard >= 100) begin
         chk("drain_timeout", 32'(scb.size()), 32'd0);
         scb.delete();
      end
   endtask

   // Pulse start with other operands so that it is present at edge e.
   task automatic spam_at(input int e);
      while (cyc < e - 1) begin
         @(negedge clk); #1;
      end
      dividend = 8'd50;
      divisor  = 8'd5;
      start    = 1'b1;
      @(negedge clk); #1;
      start    = 1'b0;
   endtask

   initial begin
      int acc;
      logic [W-1:0] ra, rb;
      repeat (3) @(negedge clk);
      #1;
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
      chk("reset_quotient", 32'(quotient), 32'd0);
      chk("reset_remainder", 32'(remainder), 32'd0);
      chk("reset_flag", 32'(div_by_zero), 32'd0);
      rst_n = 1'b1;
      @(negedge clk); #1;

      issue(8'd200, 8'd7);
      issue(8'd5, 8'd0);
      issue(8'd10, 8'd3);
      issue(8'd255, 8'd1);
      issue(8'd3, 8'd200);
      drain();
      repeat (20) begin
         @(negedge clk); #1;
      end

      // Starts during BUSY and on the done edge must be ignored.
      issue(8'd100, 8'd9);
      acc = scb[0].acc;
      spam_at(acc + 3);
      spam_at(acc + W + 1);
      drain();
      repeat (3) begin
         @(negedge clk); #1;
      end

      // Reset mid-division aborts with no done pulse.
      issue(8'd77, 8'd6);
      acc = scb[0].acc;
      while (cyc < acc + 3) begin
         @(negedge clk); #1;
      end
      rst_n = 1'b0;
      scb.delete();
      last_q = '0; last_r = '0; last_f = 1'b0; last_done = -1;
      #1;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_quotient", 32'(quotient), 32'd0);
      chk("abort_remainder", 32'(remainder), 32'd0);
      chk("abort_flag", 32'(div_by_zero), 32'd0);
      repeat (2) @(negedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk); #1;
      issue(8'd77, 8'd6);

`ifdef DIVIDER_SIGNED_EN
      issue(8'h9C, 8'd7);
      issue(8'h80, 8'hFF);
      issue(8'h80, 8'h00);
      issue(8'h7F, 8'hFE);
`endif

      // Randomized operations, including zero and small divisors.
      for (int i = 0; i < 150; i++) begin
         ra = W'($urandom);
         case ($urandom_range(0, 7))
            0:       rb = '0;
            1, 2:    rb = W'($urandom_range(1, 15));
            3:       ra = 8'h80;
            default: rb = W'($urandom);
         endcase
         if (ra == 8'h80 && $urandom_range(0, 1) == 1) rb = 8'hFF;
         else if (rb === 'x) rb = W'($urandom);
         issue(ra, rb);
         repeat ($urandom_range(0, 2)) begin
            @(negedge clk); #1;
         end
      end
      drain();
      repeat (4) begin
         @(negedge clk); #1;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
